// File: rtl/keypad_operand_entry.sv
// 4x4 hex keypad scanner with debounce; accepted keys shift into a 16-bit operand.
// Optional macro KEYPAD_OVERFLOW_LOCK_EN freezes Operand once four digits are entered.
module keypad_operand_entry #(
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 4
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [3:0]  Row,
    input  logic        Clear,
    output logic [3:0]  Col,
    output logic [15:0] Operand,
    output logic [3:0]  KeyCode,
    output logic        KeyValid,
    output logic [2:0]  DigitCount
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam logic [PW-1:0] DIV_LAST = PW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DEB_N    = CW'(DEBOUNCE);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_HOLD,
        ST_RELEASE
    } state_t;

    state_t       state_q, state_d;
    logic [3:0]   row_s1_q, row_s1_d, row_s2_q, row_s2_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [CW-1:0] stable_q, stable_d;
    logic [1:0]   col_idx_q, col_idx_d;
    logic [1:0]   row_idx_q, row_idx_d;
    logic [15:0]  operand_q, operand_d;
    logic [3:0]   key_code_q, key_code_d;
    logic         key_valid_q, key_valid_d;
    logic [2:0]   digit_count_q, digit_count_d;

    logic         tick;
    logic         any_low;
    logic [1:0]   low_idx;
    logic         key_low;
    logic         commit;
    logic [3:0]   commit_code;

    always_comb begin
        row_s1_d = Row;
        row_s2_d = row_s1_q;
        tick     = (pre_q == DIV_LAST);
        pre_d    = tick ? '0 : pre_q + PW'(1);
        any_low  = ~&row_s2_q;
        key_low  = ~row_s2_q[row_idx_q];
        // Lowest-numbered low row wins when several are pressed at once
        low_idx  = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!row_s2_q[i]) low_idx = 2'(i);
        end
    end

    // Scan/debounce state machine
    always_comb begin
        state_d     = state_q;
        col_idx_d   = col_idx_q;
        row_idx_d   = row_idx_q;
        stable_d    = stable_q;
        commit      = 1'b0;
        commit_code = {row_idx_q, col_idx_q};
        if (tick) begin
            unique case (state_q)
                ST_SCAN: begin
                    if (any_low) begin
                        row_idx_d   = low_idx;
                        stable_d    = CNT_ONE;
                        commit_code = {low_idx, col_idx_q};
                        if (DEB_N == CNT_ONE) begin
                            commit  = 1'b1;
                            state_d = ST_HOLD;
                        end else begin
                            state_d = ST_DEBOUNCE;
                        end
                    end else begin
                        col_idx_d = col_idx_q + 2'd1;
                    end
                end
                ST_DEBOUNCE: begin
                    if (key_low) begin
                        stable_d = stable_q + CNT_ONE;
                        if (stable_q + CNT_ONE == DEB_N) begin
                            commit  = 1'b1;
                            state_d = ST_HOLD;
                        end
                    end else begin
                        stable_d  = '0;
                        col_idx_d = col_idx_q + 2'd1;
                        state_d   = ST_SCAN;
                    end
                end
                ST_HOLD: begin
                    if (!key_low) begin
                        stable_d = CNT_ONE;
                        if (DEB_N == CNT_ONE) begin
                            stable_d  = '0;
                            col_idx_d = col_idx_q + 2'd1;
                            state_d   = ST_SCAN;
                        end else begin
                            state_d = ST_RELEASE;
                        end
                    end
                end
                ST_RELEASE: begin
                    if (!key_low) begin
                        stable_d = stable_q + CNT_ONE;
                        if (stable_q + CNT_ONE == DEB_N) begin
                            stable_d  = '0;
                            col_idx_d = col_idx_q + 2'd1;
                            state_d   = ST_SCAN;
                        end
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
                default: state_d = ST_SCAN;
            endcase
        end
    end

    // Operand datapath; Clear overrides a same-cycle commit except for KeyCode
    always_comb begin
        operand_d     = operand_q;
        key_code_d    = key_code_q;
        key_valid_d   = 1'b0;
        digit_count_d = digit_count_q;
        if (commit) begin
            key_code_d    = commit_code;
            key_valid_d   = 1'b1;
            digit_count_d = (digit_count_q == 3'd4) ? 3'd4 : digit_count_q + 3'd1;
`ifdef KEYPAD_OVERFLOW_LOCK_EN
            if (digit_count_q != 3'd4) operand_d = {operand_q[11:0], commit_code};
`else
            operand_d = {operand_q[11:0], commit_code};
`endif
        end
        if (Clear) begin
            operand_d     = '0;
            digit_count_d = '0;
            key_valid_d   = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q       <= ST_SCAN;
            row_s1_q      <= 4'hF;
            row_s2_q      <= 4'hF;
            pre_q         <= '0;
            stable_q      <= '0;
            col_idx_q     <= 2'd0;
            row_idx_q     <= 2'd0;
            operand_q     <= '0;
            key_code_q    <= '0;
            key_valid_q   <= 1'b0;
            digit_count_q <= '0;
        end else begin
            state_q       <= state_d;
            row_s1_q      <= row_s1_d;
            row_s2_q      <= row_s2_d;
            pre_q         <= pre_d;
            stable_q      <= stable_d;
            col_idx_q     <= col_idx_d;
            row_idx_q     <= row_idx_d;
            operand_q     <= operand_d;
            key_code_q    <= key_code_d;
            key_valid_q   <= key_valid_d;
            digit_count_q <= digit_count_d;
        end
    end

    assign Col        = ~(4'b0001 << col_idx_q);
    assign Operand    = operand_q;
    assign KeyCode    = key_code_q;
    assign KeyValid   = key_valid_q;
    assign DigitCount = digit_count_q;

endmodule

// File: tb/tb_keypad_operand_entry.sv
// Bench for keypad_operand_entry: a keypad model drives Row from Col, expected
// commits are queued at press time and a monitor checks every KeyValid pulse.
module tb_keypad_operand_entry;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        Clear;
    logic [3:0]  Row;
    logic [3:0]  Col;
    logic [15:0] Operand;
    logic [3:0]  KeyCode;
    logic        KeyValid;
    logic [2:0]  DigitCount;

    logic        pressed;
    logic [1:0]  key_r, key_c;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [3:0]  code;
        logic [15:0] op;
        logic [2:0]  cnt;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

`ifdef KEYPAD_OVERFLOW_LOCK_EN
    localparam logic [15:0] OP_FIFTH = 16'h1234;
`else
    localparam logic [15:0] OP_FIFTH = 16'h2345;
`endif

    keypad_operand_entry #(.SCAN_DIV(4), .DEBOUNCE(2)) dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .Row       (Row),
        .Clear     (Clear),
        .Col       (Col),
        .Operand   (Operand),
        .KeyCode   (KeyCode),
        .KeyValid  (KeyValid),
        .DigitCount(DigitCount)
    );

    always #5 CLK = ~CLK;

    // Keypad: a pressed key pulls its row low only while its column is driven
    always_comb begin
        Row = 4'hF;
        if (pressed && (Col[key_c] == 1'b0)) Row[key_r] = 1'b0;
    end

    task automatic check(input string name, input int act, input int want);
        n_checks++;
        if (act != want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
        end
    endtask

    always @(negedge CLK) begin
        if (KeyValid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_keyvalid", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("keycode", int'(KeyCode), int'(mon_e.code));
                check("operand", int'(Operand), int'(mon_e.op));
                check("digitcount", int'(DigitCount), int'(mon_e.cnt));
            end
        end
    end

    task automatic expect_key(input logic [3:0] code, input logic [15:0] op, input logic [2:0] cnt);
        exp_t e;
        e.code = code;
        e.op   = op;
        e.cnt  = cnt;
        exp_q.push_back(e);
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (KeyValid !== 1'b1 && n < 60) begin
            @(negedge CLK);
            n++;
        end
        if (KeyValid !== 1'b1) check(name, 0, 1);
    endtask

    task automatic set_key(input logic [3:0] k);
        key_r = k[3:2];
        key_c = k[1:0];
    endtask

    task automatic press_release(input logic [3:0] k, input logic [15:0] op, input logic [2:0] cnt);
        logic [3:0] ec;
        expect_key(k, op, cnt);
        set_key(k);
        pressed = 1'b1;
        wait_valid("keyvalid_timeout");
        ec = 4'hF;
        ec[key_c] = 1'b0;
        repeat (12) @(negedge CLK);
        check("col_frozen_hold", int'(Col), int'(ec));
        pressed = 1'b0;
        repeat (24) @(negedge CLK);
    endtask

    task automatic wait_col(input logic [3:0] target);
        int n = 0;
        while (Col == target && n < 40) begin @(negedge CLK); n++; end
        while (Col != target && n < 40) begin @(negedge CLK); n++; end
        if (Col != target) check("col_align_timeout", int'(Col), int'(target));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_col"}, int'(Col), 'hE);
        check({tag, "_operand"}, int'(Operand), 0);
        check({tag, "_keycode"}, int'(KeyCode), 0);
        check({tag, "_keyvalid"}, int'(KeyValid), 0);
        check({tag, "_digitcount"}, int'(DigitCount), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] prev;
        int since;
        int changes;

        Reset   = 1'b1;
        Clear   = 1'b0;
        pressed = 1'b0;
        key_r   = 2'd0;
        key_c   = 2'd0;
        repeat (3) @(negedge CLK);
        check_reset_outputs("reset");
        Reset = 1'b0;

        // Idle scan: one column step every 4 clocks, rotating through all four
        prev    = Col;
        since   = 0;
        changes = 0;
        repeat (40) begin
            @(negedge CLK);
            since++;
            if (Col != prev) begin
                check("col_order", int'(Col), int'({prev[2:0], prev[3]}));
                check("col_period", since, 4);
                prev = Col;
                since = 0;
                changes++;
            end
        end
        check("col_changes", changes, 10);

        // Key 6 (row 1, column 2), held for several ticks
        press_release(4'h6, 16'h0006, 3'd1);

        Clear = 1'b1;
        @(negedge CLK);
        Clear = 1'b0;
        check("clear_operand", int'(Operand), 0);
        check("clear_digitcount", int'(DigitCount), 0);

        press_release(4'h1, 16'h0001, 3'd1);
        press_release(4'h2, 16'h0012, 3'd2);
        press_release(4'h3, 16'h0123, 3'd3);
        press_release(4'h4, 16'h1234, 3'd4);
        press_release(4'h5, OP_FIFTH, 3'd4);

        // Bounce: low on exactly one tick while column 1 is driven
        wait_col(4'b1101);
        set_key(4'h1);
        pressed = 1'b1;
        repeat (4) @(negedge CLK);
        check("bounce_col_frozen", int'(Col), 'hD);
        pressed = 1'b0;
        repeat (4) @(negedge CLK);
        check("bounce_col_resume", int'(Col), 'hB);
        repeat (8) @(negedge CLK);

        // Clear on the commit clock of key A
        wait_col(4'b1011);
        set_key(4'hA);
        pressed = 1'b1;
        repeat (7) @(negedge CLK);
        Clear = 1'b1;
        @(negedge CLK);
        Clear = 1'b0;
        check("clrcommit_operand", int'(Operand), 0);
        check("clrcommit_digitcount", int'(DigitCount), 0);
        check("clrcommit_keyvalid", int'(KeyValid), 0);
        check("clrcommit_keycode", int'(KeyCode), 'hA);
        check("clrcommit_col", int'(Col), 'hB);
        repeat (8) @(negedge CLK);
        pressed = 1'b0;
        repeat (24) @(negedge CLK);

        // Reset while holding key 9; the still-pressed key must commit once afterwards
        expect_key(4'h9, 16'h0009, 3'd1);
        set_key(4'h9);
        pressed = 1'b1;
        wait_valid("keyvalid_timeout_pre_reset");
        repeat (6) @(negedge CLK);
        #2 Reset = 1'b1;
        #1 check_reset_outputs("midhold_reset");
        @(negedge CLK);
        repeat (2) @(negedge CLK);
        expect_key(4'h9, 16'h0009, 3'd1);
        Reset = 1'b0;
        wait_valid("keyvalid_timeout_post_reset");
        repeat (16) @(negedge CLK);
        pressed = 1'b0;
        repeat (24) @(negedge CLK);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
